// File: rtl/ram_stream_feeder.sv
// Streams one RAM-resident frame (header + len data words) to the control part.
// A two-slot store (output register + one skid entry) hides the RAM read latency and downstream hold.
module ram_stream_feeder #(
   parameter int DATA_W = 72,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [2:0]        type_in,
   output logic              busy,
   output logic              done,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] data_out,
   output logic              en_out,
   output logic              set_out,
   output logic [2:0]        type_out,
   input  logic              hold
);

   localparam int CW = LEN_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] base_reg;
   logic [CW-1:0]     len_reg;
   logic [CW-1:0]     issue_cnt_reg, issue_cnt_next;
   logic [CW-1:0]     xfer_cnt_reg;
   logic              rd_pending_reg, rd_first_reg;
   logic              skid_valid_reg, skid_set_reg;
   logic [DATA_W-1:0] skid_data_reg;
   logic [DATA_W-1:0] data_reg;
   logic              en_reg, set_reg, done_reg;
   logic [2:0]        type_reg;

   logic              accept, xfer, out_free, last_xfer, issue;
   logic [1:0]        outstanding;
   logic [ADDR_W-1:0] issue_lo;

   generate
      if (CW >= ADDR_W) begin : g_addr_trunc
         assign issue_lo = issue_cnt_reg[ADDR_W-1:0];
      end else begin : g_addr_ext
         assign issue_lo = {{(ADDR_W-CW){1'b0}}, issue_cnt_reg};
      end
   endgenerate

   assign xfer      = en_reg & ~hold;
   assign out_free  = ~en_reg | ~hold;
   assign accept    = (state_reg == IDLE) && start && !done_reg;
   assign last_xfer = (state_reg != IDLE) && xfer && (xfer_cnt_reg == len_reg);
   // Words held or arriving after this edge; a word leaving this edge frees its slot.
   assign outstanding = 2'(en_reg) + 2'(skid_valid_reg) + 2'(rd_pending_reg) - 2'(xfer);

   always_ff @(posedge clk) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      issue_cnt_next = issue_cnt_reg;
      issue          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next     = RUN;
               issue_cnt_next = '0;
            end
         end
         RUN: begin
            if (outstanding < 2'd2) begin
               issue          = 1'b1;
               issue_cnt_next = issue_cnt_reg + CW'(1);
               if (issue_cnt_reg == len_reg) state_next = DRAIN;
            end
         end
         DRAIN: ;
         default: state_next = IDLE;
      endcase
      if (last_xfer) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         base_reg       <= '0;
         len_reg        <= '0;
         issue_cnt_reg  <= '0;
         xfer_cnt_reg   <= '0;
         rd_pending_reg <= 1'b0;
         rd_first_reg   <= 1'b0;
         skid_valid_reg <= 1'b0;
         skid_set_reg   <= 1'b0;
         skid_data_reg  <= '0;
         data_reg       <= '0;
         en_reg         <= 1'b0;
         set_reg        <= 1'b0;
         type_reg       <= '0;
         done_reg       <= 1'b0;
      end else begin
         issue_cnt_reg  <= issue_cnt_next;
         done_reg       <= last_xfer;
         rd_pending_reg <= issue;
         rd_first_reg   <= issue && (issue_cnt_reg == '0);
         if (accept) begin
            base_reg     <= base_addr;
            len_reg      <= {1'b0, len};
            type_reg     <= type_in;
            xfer_cnt_reg <= '0;
         end else if (xfer) begin
            xfer_cnt_reg <= xfer_cnt_reg + CW'(1);
         end
         // Skid entry is always older than the word arriving from RAM.
         if (out_free) begin
            if (skid_valid_reg) begin
               data_reg       <= skid_data_reg;
               set_reg        <= skid_set_reg;
               en_reg         <= 1'b1;
               skid_valid_reg <= rd_pending_reg;
               skid_data_reg  <= ram_rdata;
               skid_set_reg   <= rd_first_reg;
            end else if (rd_pending_reg) begin
               data_reg <= ram_rdata;
               set_reg  <= rd_first_reg;
               en_reg   <= 1'b1;
            end else begin
               en_reg  <= 1'b0;
               set_reg <= 1'b0;
            end
         end else if (rd_pending_reg) begin
            skid_data_reg  <= ram_rdata;
            skid_set_reg   <= rd_first_reg;
            skid_valid_reg <= 1'b1;
         end
      end
   end

   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;
   assign ram_re   = issue;
   assign ram_addr = issue ? (base_reg + issue_lo) : '0;
   assign data_out = data_reg;
   assign en_out   = en_reg;
   assign set_out  = set_reg;
   assign type_out = type_reg;

endmodule

// File: tb/tb_ram_stream_feeder.sv
// Bench for ram_stream_feeder: a frame-level model (expected word queue, address rule,
// latency and done timing) checked every cycle, plus literal per-test expectations.
module tb_ram_stream_feeder;

   logic        clk = 1'b0;
   logic        reset, start, hold;
   logic [9:0]  base_addr;
   logic [9:0]  len;
   logic [2:0]  type_in;
   logic        busy, done, ram_re, en_out, set_out;
   logic [9:0]  ram_addr;
   logic [71:0] ram_rdata, data_out;
   logic [2:0]  type_out;

   ram_stream_feeder dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
      .type_in(type_in), .busy(busy), .done(done), .ram_re(ram_re), .ram_addr(ram_addr),
      .ram_rdata(ram_rdata), .data_out(data_out), .en_out(en_out), .set_out(set_out),
      .type_out(type_out), .hold(hold)
   );

   always #5 clk = ~clk;

   logic [71:0] mem [0:1023];
   always @(posedge clk) begin
      if (ram_re) ram_rdata <= mem[ram_addr];
      else        ram_rdata <= {$urandom, $urandom, 8'hEE};
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input bit ok, input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // frame-level model state
   logic [71:0] exp_d[$];
   bit          exp_s[$];
   int          cyc = 0, start_cyc = 0, done_cyc = 0;
   int          m_base = 0, m_len = 0, m_type = 0;
   int          issued = 0, xfers = 0, frames_done = 0;
   bit          active = 0, done_due = 0, zero_due = 0, first_en_seen = 0, in_done;
   bit          held = 0, held_set;
   logic [71:0] held_data, exp_word;
   bit          exp_set;
   int          addr_log[$];
   int          xfer_cyc_log[$];

   always @(negedge clk) begin
      cyc++;
      if (zero_due) begin
         zero_due = 0;
         chk(data_out == '0 && !en_out && !set_out && type_out == '0 && !busy && !done && !ram_re,
             "reset_zero", {data_out[63:0], en_out, set_out, type_out, busy, done, ram_re},
             72'd0);
      end
      if (!reset) begin
         exp_d.delete(); exp_s.delete();
         active = 0; done_due = 0; held = 0; zero_due = 1;
      end else begin
         in_done = 0;
         if (done_due) begin
            chk(done && !busy, "done_pulse", {done, busy}, 72'b10);
            done_due = 0; active = 0; in_done = 1;
            done_cyc = cyc; frames_done++;
         end else begin
            chk(!done, "no_done", int'(done), 0);
         end
         chk(busy == active, "busy", int'(busy), int'(active));
         if (!active) chk(!en_out, "en_idle", int'(en_out), 0);
         if (held)
            chk(en_out && data_out == held_data && set_out == held_set, "hold_stable",
                data_out, held_data);
         if (ram_re) begin
            chk(active && issued <= m_len, "re_legal", issued, m_len);
            chk(ram_addr == 10'(m_base + issued), "ram_addr", int'(ram_addr), (m_base + issued) % 1024);
            if (issued == 0) chk(cyc == start_cyc + 1, "re_latency", cyc - start_cyc, 1);
            addr_log.push_back(int'(ram_addr));
            issued++;
         end
         if (active && en_out && !first_en_seen) begin
            first_en_seen = 1;
            chk(cyc == start_cyc + 3, "en_latency", cyc - start_cyc, 3);
         end
         if (en_out && !hold) begin
            if (exp_d.size() == 0) begin
               chk(0, "extra_word", data_out, 0);
            end else begin
               exp_word = exp_d.pop_front();
               exp_set  = exp_s.pop_front();
               chk(data_out == exp_word, "data", data_out, exp_word);
               chk(set_out == exp_set, "set", int'(set_out), int'(exp_set));
               chk(type_out == 3'(m_type), "type", int'(type_out), m_type);
               xfers++;
               xfer_cyc_log.push_back(cyc);
               if (exp_d.size() == 0) done_due = 1;
            end
         end
         chk(issued - xfers <= 2, "occupancy", issued - xfers, 2);
         held      = en_out && hold;
         held_data = data_out;
         held_set  = set_out;
         if (start && !active && !in_done) begin
            active = 1; start_cyc = cyc;
            m_base = int'(base_addr); m_len = int'(len); m_type = int'(type_in);
            issued = 0; xfers = 0; first_en_seen = 0;
            for (int i = 0; i <= m_len; i++) begin
               exp_d.push_back(mem[10'(m_base + i)]);
               exp_s.push_back(i == 0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int b, input int l, input int t);
      start = 1'b1; base_addr = 10'(b); len = 10'(l); type_in = 3'(t);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (frames_done < target && n < 300) begin
         tick();
         n++;
      end
      chk(frames_done >= target, "frame_timeout", frames_done, target);
   endtask

   task automatic wait_xfers(input int target);
      int n = 0;
      while (xfers < target && n < 100) begin
         tick();
         n++;
      end
      chk(xfers >= target, "xfer_timeout", xfers, target);
   endtask

   task automatic clear_logs();
      addr_log.delete();
      xfer_cyc_log.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, n;
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, 8'(i)};
      reset = 1'b0; start = 1'b0; hold = 1'b0;
      base_addr = '0; len = '0; type_in = '0;
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // 1: basic 4-word frame, no stalls
      clear_logs(); f0 = frames_done;
      do_start('h010, 3, 5);
      wait_frames(f0 + 1);
      chk(addr_log.size() == 4, "t1_re_count", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         chk(addr_log[i] == 'h010 + i, "t1_addr", addr_log[i], 'h010 + i);
      chk(xfer_cyc_log.size() == 4, "t1_words", xfer_cyc_log.size(), 4);
      if (xfer_cyc_log.size() == 4) begin
         chk(xfer_cyc_log[3] - xfer_cyc_log[0] == 3, "t1_no_gap", xfer_cyc_log[3] - xfer_cyc_log[0], 3);
         chk(done_cyc == xfer_cyc_log[3] + 1, "t1_done_time", done_cyc - xfer_cyc_log[3], 1);
      end
      tick();

      // 2: header-only frame
      clear_logs(); f0 = frames_done;
      do_start('h123, 0, 2);
      wait_frames(f0 + 1);
      chk(addr_log.size() == 1, "t2_re_count", addr_log.size(), 1);
      chk(xfer_cyc_log.size() == 1, "t2_words", xfer_cyc_log.size(), 1);
      tick();

      // 3: 3-cycle stall after the 2nd transfer
      clear_logs(); f0 = frames_done;
      do_start('h040, 5, 3);
      wait_xfers(2);
      hold = 1'b1;
      repeat (3) tick();
      hold = 1'b0;
      wait_frames(f0 + 1);
      chk(xfer_cyc_log.size() == 6, "t3_words", xfer_cyc_log.size(), 6);
      chk(addr_log.size() == 6, "t3_re_count", addr_log.size(), 6);
      tick();

      // 3b: irregular stall pattern
      clear_logs(); f0 = frames_done;
      do_start('h0A0, 7, 1);
      n = 0;
      while (frames_done < f0 + 1 && n < 200) begin
         hold = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      hold = 1'b0;
      wait_frames(f0 + 1);
      chk(xfer_cyc_log.size() == 8, "t3b_words", xfer_cyc_log.size(), 8);
      tick();

      // 4: address wrap
      clear_logs(); f0 = frames_done;
      do_start('h3FE, 3, 1);
      wait_frames(f0 + 1);
      chk(addr_log.size() == 4, "t4_re_count", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         chk(addr_log[0] == 'h3FE, "t4_addr0", addr_log[0], 'h3FE);
         chk(addr_log[1] == 'h3FF, "t4_addr1", addr_log[1], 'h3FF);
         chk(addr_log[2] == 'h000, "t4_addr2", addr_log[2], 'h000);
         chk(addr_log[3] == 'h001, "t4_addr3", addr_log[3], 'h001);
      end
      tick();

      // 5: start while busy and in the done cycle is ignored; one cycle later it is taken
      clear_logs(); f0 = frames_done;
      do_start('h080, 4, 6);
      tick();
      do_start('h300, 1, 7);
      n = 0;
      while (!done_due && n < 100) begin
         tick();
         n++;
      end
      chk(done_due, "t5_done_timeout", int'(done_due), 1);
      start = 1'b1; base_addr = 10'h300; len = 10'd1; type_in = 3'd7;
      tick();
      base_addr = 10'h0C0; len = 10'd2; type_in = 3'd4;
      tick();
      start = 1'b0;
      wait_frames(f0 + 2);
      tick();
      chk(frames_done == f0 + 2, "t5_frames", frames_done - f0, 2);
      chk(addr_log.size() == 8, "t5_re_count", addr_log.size(), 8);
      if (addr_log.size() == 8) chk(addr_log[5] == 'h0C0, "t5_new_base", addr_log[5], 'h0C0);
      tick();

      // 6: reset after 2 transfers, then a clean frame
      clear_logs(); f0 = frames_done;
      do_start('h200, 6, 2);
      wait_xfers(2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      repeat (5) tick();
      chk(frames_done == f0, "t6_no_done", frames_done - f0, 0);
      clear_logs();
      do_start('h210, 2, 3);
      wait_frames(f0 + 1);
      chk(xfer_cyc_log.size() == 3, "t6_words", xfer_cyc_log.size(), 3);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
